// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS-15 checker: state encoding, taps and helper functions.
package prbs_pkg;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } prbs_state_e;

  // x^15 + x^14 + 1: new bit is s[14] ^ s[13]
  localparam int unsigned PRBS15_TAP_HI = 14;
  localparam int unsigned PRBS15_TAP_LO = 13;

  typedef struct packed {
    logic [14:0] state;
    logic [7:0]  data;
  } prbs_step_t;

  // Advance eight bit-steps; the first generated bit lands in data[7].
  function automatic prbs_step_t prbs15_next(input logic [14:0] s);
    prbs_step_t r;
    logic       b;
    r.state = s;
    r.data  = '0;
    for (int i = 0; i < 8; i++) begin
      b       = r.state[PRBS15_TAP_HI] ^ r.state[PRBS15_TAP_LO];
      r.state = {r.state[13:0], b};
      r.data  = {r.data[6:0], b};
    end
    return r;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/prbs_err_window.sv
// Sliding error window: counts errored bytes per WIN_LEN accepted bytes and flags loss of lock.
module prbs_err_window
  import prbs_pkg::*;
#(
  parameter int unsigned WIN_LEN    = 64,
  parameter int unsigned ERR_THRESH = 4
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic step,
  input  logic err,
  input  logic flush,
  output logic loss,
  output logic wrap
);

  localparam int unsigned PW = $clog2(WIN_LEN);
  localparam int unsigned EW = $clog2(WIN_LEN + 1);

  logic [PW-1:0] pos_q, pos_d;
  logic [EW-1:0] errs_q, errs_d, errs_sum;

  // The current byte's error is folded in before any wrap reset.
  assign errs_sum = errs_q + EW'(err);
  assign wrap     = step && (pos_q == PW'(WIN_LEN - 1));
  assign loss     = step && err && (errs_sum >= EW'(ERR_THRESH));

  always_comb begin
    pos_d  = pos_q;
    errs_d = errs_q;
    if (flush) begin
      pos_d  = '0;
      errs_d = '0;
    end else if (step) begin
      pos_d  = pos_q + PW'(1);
      errs_d = wrap ? '0 : errs_sum;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pos_q  <= '0;
      errs_q <= '0;
    end else begin
      pos_q  <= pos_d;
      errs_q <= errs_d;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS-15 checker: self-seeds from the data, verifies a run of bytes, then counts
// errors while locked and drops lock when the error window overflows.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned WIN_LEN    = 64,
  parameter int unsigned ERR_THRESH = 4
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [7:0]  in,
  input  logic        in_valid,
  input  logic        clear,
  output logic        locked,
  output logic        byte_err,
  output logic        sync_lost,
  output logic [31:0] bit_err_cnt,
  output logic [15:0] byte_err_cnt
);

  prbs_state_e state_q, state_d;
  logic [14:0] lfsr_q, lfsr_d;
  logic [7:0]  run_q, run_d;
  logic        seed_have_q, seed_have_d;
  logic [6:0]  seed_low_q, seed_low_d;
  logic        locked_q, locked_d;
  logic        byte_err_q, byte_err_d;
  logic        sync_lost_q, sync_lost_d;
  logic [31:0] bit_err_q, bit_err_d, bit_base;
  logic [15:0] byte_cnt_q, byte_cnt_d, byte_base;
  logic [32:0] bit_sum;

  prbs_step_t  nxt;
  logic        mismatch, win_step, err_hit, win_loss, unused_wrap;
  logic [3:0]  pc;

  assign nxt      = prbs15_next(lfsr_q);
  assign mismatch = (in != nxt.data);
  assign pc       = popcount8(in ^ nxt.data);
  assign win_step = in_valid && (state_q == LOCKED);
  assign err_hit  = win_step && mismatch;

  prbs_err_window #(
    .WIN_LEN    (WIN_LEN),
    .ERR_THRESH (ERR_THRESH)
  ) u_window (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .step  (win_step),
    .err   (mismatch),
    .flush (state_q != LOCKED),
    .loss  (win_loss),
    .wrap  (unused_wrap)
  );

  // Error counters: clear wins over the old value but not over this byte's increment.
  always_comb begin
    bit_base   = clear ? 32'd0 : bit_err_q;
    byte_base  = clear ? 16'd0 : byte_cnt_q;
    bit_sum    = {1'b0, bit_base} + {29'd0, pc};
    bit_err_d  = bit_base;
    byte_cnt_d = byte_base;
    if (err_hit) begin
      bit_err_d  = bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
      byte_cnt_d = (byte_base == 16'hFFFF) ? byte_base : byte_base + 16'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    run_d       = run_q;
    seed_have_d = seed_have_q;
    seed_low_d  = seed_low_q;
    byte_err_d  = 1'b0;
    sync_lost_d = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        SEED: begin
          if (!seed_have_q) begin
            seed_low_d  = in[6:0];
            seed_have_d = 1'b1;
          end else begin
            lfsr_d      = {seed_low_q, in};
            seed_have_d = 1'b0;
            run_d       = 8'd0;
            state_d     = VERIFY;
          end
        end
        VERIFY: begin
          if (mismatch) begin
            // The failing byte becomes the first seed byte.
            state_d     = SEED;
            seed_low_d  = in[6:0];
            seed_have_d = 1'b1;
          end else begin
            lfsr_d = nxt.state;
            run_d  = run_q + 8'd1;
            if (run_q == 8'(LOCK_CNT - 1)) state_d = LOCKED;
          end
        end
        LOCKED: begin
          lfsr_d     = nxt.state;
          byte_err_d = mismatch;
          if (win_loss) begin
            state_d     = SEED;
            seed_have_d = 1'b0;
            sync_lost_d = 1'b1;
          end
        end
        default: state_d = SEED;
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= SEED;
      lfsr_q      <= '0;
      run_q       <= '0;
      seed_have_q <= 1'b0;
      seed_low_q  <= '0;
      locked_q    <= 1'b0;
      byte_err_q  <= 1'b0;
      sync_lost_q <= 1'b0;
      bit_err_q   <= '0;
      byte_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      run_q       <= run_d;
      seed_have_q <= seed_have_d;
      seed_low_q  <= seed_low_d;
      locked_q    <= locked_d;
      byte_err_q  <= byte_err_d;
      sync_lost_q <= sync_lost_d;
      bit_err_q   <= bit_err_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  assign locked       = locked_q;
  assign byte_err     = byte_err_q;
  assign sync_lost    = sync_lost_q;
  assign bit_err_cnt  = bit_err_q;
  assign byte_err_cnt = byte_cnt_q;

endmodule
